instr_reg_arbiter: RTL
======================

INSTR_REG_ARBITER -- requirements
Module: instr_reg_arbiter

Interface
REQ-001 Parameter OVERWRITE, default 0; 0 = stall writers when all slots are written, 1 = wrap and overwrite the oldest slot.
REQ-002 Parameter DEPTH, default 32; number of register slots, SHALL equal 2**$bits(address_t).
REQ-003 clk  in  1  single clock; all logic updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clear  in  1  pulse; empties the register bookkeeping.
REQ-006 req_valid  in  2  per-requester write request, index 0/1.
REQ-007 req_ready  out  2  per-requester accept; a transfer occurs when valid&ready.
REQ-008 req_opcode  in  2 x opcode_t  per-requester opcode.
REQ-009 req_operand_a, req_operand_b  in  2 x operand_t  per-requester operands.
REQ-010 load_en  out  1  write strobe to the instruction register.
REQ-011 write_pointer  out  address_t  write slot.
REQ-012 opcode, operand_a, operand_b  out  opcode_t/operand_t  write data.
REQ-013 rd_req  in  1  read request; rd_addr  in  address_t  slot to read.
REQ-014 read_pointer  out  address_t  read slot to the register.
REQ-015 instruction_word  in  instruction_t  register read data.
REQ-016 rd_valid  out  1; rd_data  out  instruction_t; rd_err  out  1 (slot never written).
REQ-017 count  out  $clog2(DEPTH)+1 bits  written-slot count; full  out  1.

Function
REQ-018 FSM states: RUN, FULL, CLEAR; reset enters RUN.
REQ-019 RUN: req_ready is one-hot on the granted requester; only one requester is accepted per cycle.
REQ-020 Arbitration is round-robin: when both valid, grant the requester not granted last; a sole valid requester is always granted.
REQ-021 Last-grant pointer updates only on an accepted transfer; after reset it favours requester 0.
REQ-022 Accept at cycle t -> load_en=1 at t+1 with the captured fields and write_pointer=wp; wp increments at t+1; back-to-back accepts give load_en every cycle.
REQ-023 wp wraps DEPTH-1 -> 0.
REQ-024 count increments per load_en and saturates at DEPTH; full = (count==DEPTH).
REQ-025 RUN -> FULL when the accept that brings count to DEPTH occurs and OVERWRITE=0; FULL holds req_ready=0.
REQ-026 OVERWRITE=1: FULL is never entered, writes continue and wrap, count stays DEPTH.
REQ-027 A per-slot written bitmap sets on load_en.
REQ-028 Read: rd_req at t -> read_pointer=rd_addr registered at t+1; rd_valid=1 at t+2 with rd_data=instruction_word sampled at t+1; rd_err = slot unwritten at t+1.
REQ-029 Reads are pipelined one per cycle and are independent of writes and FSM state.
REQ-030 Same-slot write and read in one cycle returns the pre-write contents.
REQ-031 clear from any state -> CLEAR for one cycle: req_ready=0, wp=0, count=0, bitmap=0, pending load_en suppressed; next state RUN.
REQ-032 clear has priority over a simultaneous accept; that accept does not occur.
REQ-033 In-flight reads complete during CLEAR with rd_err evaluated after bitmap clear.

Reset
REQ-034 reset at any cycle, including mid-write or mid-read: state=RUN, req_ready=0 during reset, load_en=0, wp=0, read_pointer=0, count=0, full=0, rd_valid=0, rd_err=0, rd_data=0, bitmap=0, opcode/operands=0.
REQ-035 reset overrides clear and all in-flight operations; nothing issued before reset appears afterward.

Structure
REQ-036 opcode_t, operand_t, address_t and instruction_t come from instr_register_pkg; add arb_state_t (RUN/FULL/CLEAR) there.
REQ-037 One sub-module rr_arbiter2 (2-way round-robin grant with last-grant register).

Verification
REQ-038 Req0 alone, 3 back-to-back writes -> load_en on 3 consecutive cycles, write_pointer 0,1,2, count=3.
REQ-039 Both valid for 4 cycles -> grants 0,1,0,1; fields appear at the register in that order.
REQ-040 OVERWRITE=0, 32 writes -> full=1, req_ready=00, 33rd held; clear -> count=0 and the 33rd lands at slot 0.
REQ-041 OVERWRITE=1, 34 writes -> slots 0,1 overwritten, count=32, full=1, ready stays asserted.
REQ-042 Read slot 5 unwritten -> rd_valid at t+2 with rd_err=1; after a write to 5, re-read -> rd_err=0 with matching data.
REQ-043 reset asserted for one cycle during a burst of accepts -> all outputs at reset values and the next write goes to slot 0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read arbiter.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef logic signed [31:0] operand_t;

   typedef logic [4:0] address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic [1:0] {
      RUN,
      FULL,
      CLEAR
   } arb_state_t;

   localparam int unsigned NUM_SLOTS = 2**$bits(address_t);

endpackage

// File: rtl/instr_reg_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. The grant is combinational from valid; the
// last-grant register only moves when the caller reports an accepted transfer.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   // 1 when requester 1 won most recently; resets to 1 so requester 0 wins first.
   logic last_grant;

   // Sole requester always wins; on contention the one not granted last wins.
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Remember who won, but only for transfers that actually happened.
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (advance)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/instr_reg_arbiter.sv
// Arbitrates two writers into the instruction register and pipelines reads
// back out, tracking which slots hold valid data.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | accepting writes, one requester per cycle, round-robin
//   FULL  | every slot written, writers stalled until clear
//   CLEAR | one-cycle bookkeeping flush after a clear pulse
module instr_reg_arbiter
   import instr_register_pkg::*;
#(
   parameter bit OVERWRITE = 1'b0,
   parameter int DEPTH     = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  opcode_t                req_opcode    [2],
   input  operand_t               req_operand_a [2],
   input  operand_t               req_operand_b [2],
   output logic                   load_en,
   output address_t               write_pointer,
   output opcode_t                opcode,
   output operand_t               operand_a,
   output operand_t               operand_b,
   input  logic                   rd_req,
   input  address_t               rd_addr,
   output address_t               read_pointer,
   input  instruction_t           instruction_word,
   output logic                   rd_valid,
   output instruction_t           rd_data,
   output logic                   rd_err,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int CW = $clog2(DEPTH) + 1;

   arb_state_t       state;
   logic [1:0]       grant;
   logic             accept;
   logic             sel;
   address_t         wp;
   logic [DEPTH-1:0] written;
   logic             rd_pend;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .valid   (req_valid),
      .advance (accept),
      .grant   (grant)
   );

   // Ready is masked by clear as well, so a requester never sees a handshake
   // that clear is about to discard.
   assign req_ready = (state == RUN && !reset && !clear) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign sel       = req_ready[1];
   assign full      = (count == CW'(DEPTH));

   // Write path and FSM: capture the winner's fields, advance wp, track count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         load_en       <= 1'b0;
         write_pointer <= '0;
         wp            <= '0;
         count         <= '0;
         opcode        <= ZERO;
         operand_a     <= '0;
         operand_b     <= '0;
      end else if (clear) begin
         state   <= CLEAR;
         load_en <= 1'b0;
         wp      <= '0;
         count   <= '0;
      end else begin
         load_en <= accept;
         if (accept) begin
            write_pointer <= wp;
            wp            <= wp + address_t'(1);
            opcode        <= req_opcode[sel];
            operand_a     <= req_operand_a[sel];
            operand_b     <= req_operand_b[sel];
            if (count != CW'(DEPTH))
               count <= count + CW'(1);
         end
         case (state)
            RUN:     if (accept && !OVERWRITE && count == CW'(DEPTH - 1))
                        state <= FULL;
            FULL:    state <= FULL;
            CLEAR:   state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Written-slot bitmap; a load landing in the clear cycle is discarded.
   always_ff @(posedge clk) begin
      if (reset || clear)
         written <= '0;
      else if (load_en)
         written[write_pointer] <= 1'b1;
   end

   // Two-stage read pipeline. A read sampled in the clear cycle sees an
   // empty bitmap, matching what the slot state will be afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_pointer <= '0;
         rd_pend      <= 1'b0;
         rd_valid     <= 1'b0;
         rd_err       <= 1'b0;
         rd_data      <= '0;
      end else begin
         rd_pend  <= rd_req;
         rd_valid <= rd_pend;
         if (rd_req)
            read_pointer <= rd_addr;
         if (rd_pend) begin
            rd_data <= instruction_word;
            rd_err  <= clear | ~written[read_pointer];
         end
      end
   end

endmodule
